// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 7-segment scanner with brightness PWM, blanking and raw-segment mode
module seg7_scan #(
  parameter int NDIGITS = 4,
  parameter int BASE    = 16,
  parameter int DIVBITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               rw,
  input  logic [31:0]        addr,
  input  logic [31:0]        data,
  output logic [31:0]        rdata,
  output logic [7:0]         seg,
  output logic [NDIGITS-1:0] an
);

  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> (32 - 4 * NDIGITS);
  localparam logic [7:0]  DIG_MASK  = 8'hFF >> (8 - NDIGITS);
  localparam logic [63:0] RAW_MASK  = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - 8 * NDIGITS);
  localparam logic [2:0]  LAST_IDX  = 3'(NDIGITS - 1);

  logic [31:0]        r_data;
  logic [7:0]         r_dp;
  logic [7:0]         r_blank;
  logic [3:0]         r_bright;
  logic               r_raw_mode;
  logic [63:0]        r_raw;
  logic [31:0]        r_rdata;
  logic [DIVBITS-1:0] r_presc;
  logic [3:0]         r_phase;
  logic [2:0]         r_idx;
  logic [7:0]         r_seg;
  logic [NDIGITS-1:0] r_an;

  logic [31:0]        w_off;
  logic               w_hit;
  logic               w_wr;
  logic               w_rd;
  logic               w_tick;
  logic [31:0]        w_rval;
  logic [3:0]         w_nib;
  logic [7:0]         w_rawb;
  logic               w_lit;
  logic [7:0]         w_seg;
  logic [NDIGITS-1:0] w_an;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Unsigned subtraction folds both window bounds into a single compare.
  assign w_off  = addr - 32'(BASE);
  assign w_hit  = (w_off < 32'd5);
  assign w_wr   = enable & rw & w_hit;
  assign w_rd   = enable & ~rw;
  assign w_tick = &r_presc;

  always_comb begin
    w_rval = 32'h0;
    if (w_hit) begin
      case (w_off[2:0])
        3'd0: w_rval = r_data;
        3'd1: w_rval = {24'h0, r_dp};
        3'd2: w_rval = {16'h0, r_blank, r_bright, 3'b000, r_raw_mode};
        3'd3: w_rval = r_raw[31:0];
        3'd4: w_rval = r_raw[63:32];
        default: w_rval = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= 32'h0;
      r_dp       <= 8'h0;
      r_blank    <= 8'h0;
      r_bright   <= 4'hF;
      r_raw_mode <= 1'b0;
      r_raw      <= 64'h0;
      r_rdata    <= 32'h0;
    end else begin
      if (w_wr) begin
        case (w_off[2:0])
          3'd0: r_data <= data & DATA_MASK;
          3'd1: r_dp   <= data[7:0] & DIG_MASK;
          3'd2: begin
            r_raw_mode <= data[0];
            r_bright   <= data[7:4];
            r_blank    <= data[15:8] & DIG_MASK;
          end
          3'd3: r_raw[31:0]  <= data & RAW_MASK[31:0];
          3'd4: r_raw[63:32] <= data & RAW_MASK[63:32];
          default: ;
        endcase
      end
      if (w_rd) r_rdata <= w_rval;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_phase <= 4'h0;
      r_idx   <= 3'd0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_tick) begin
        r_phase <= r_phase + 4'h1;
        if (r_phase == 4'hF) r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

  // Segments and anodes both derive from the same idx/phase snapshot, so they flip together.
  always_comb begin
    w_nib  = r_data[{r_idx, 2'b00} +: 4];
    w_rawb = r_raw[{r_idx, 3'b000} +: 8];
    w_lit  = (r_phase <= r_bright) && !r_blank[r_idx];
    w_seg  = 8'hFF;
    if (w_lit) w_seg = r_raw_mode ? ~w_rawb : {~r_dp[r_idx], hex7(w_nib)};
    w_an = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (w_lit && (r_idx == 3'(i))) w_an[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= 8'hFF;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign rdata = r_rdata;
  assign seg   = r_seg;
  assign an    = r_an;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan
module tb_seg7_scan;

  localparam int ND    = 4;
  localparam int BASE  = 16;
  localparam int DB    = 2;
  localparam int FRAME = 16 * (1 << DB) * ND;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          rw = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   data = 32'h0;
  logic [31:0]   rdata;
  logic [7:0]    seg;
  logic [ND-1:0] an;

  int n_checks = 0;
  int n_fail = 0;

  int         lit_cnt[ND];
  logic [7:0] seg_seen[ND];
  logic [7:0] want_seg[ND];
  int         dark_bad;
  int         multi_bad;
  int         seg_bad;
  logic [31:0] rv;

  seg7_scan #(.NDIGITS(ND), .BASE(BASE), .DIVBITS(DB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rw(rw),
    .addr(addr), .data(data), .rdata(rdata), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, want);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    enable = 1'b1; rw = 1'b1; addr = a; data = d;
    @(negedge clk);
    enable = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    enable = 1'b1; rw = 1'b0; addr = a;
    @(negedge clk);
    enable = 1'b0;
    v = rdata;
  endtask

  task automatic set_want(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    want_seg[0] = s0; want_seg[1] = s1; want_seg[2] = s2; want_seg[3] = s3;
  endtask

  task automatic scan_frame();
    int z;
    int d;
    for (int i = 0; i < ND; i++) begin
      lit_cnt[i] = 0;
      seg_seen[i] = 8'h00;
    end
    dark_bad = 0; multi_bad = 0; seg_bad = 0;
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      z = 0; d = 0;
      for (int i = 0; i < ND; i++) if (!an[i]) begin z++; d = i; end
      if (z == 0) begin
        if (seg !== 8'hFF) dark_bad++;
      end else if (z > 1) begin
        multi_bad++;
      end else begin
        if (lit_cnt[d] == 0) seg_seen[d] = seg;
        lit_cnt[d]++;
        if (seg !== want_seg[d]) seg_bad++;
      end
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_an", 32'(an), 32'hF);
    check("rst_rdata", rdata, 32'h0);

    reset = 1'b0;
    @(negedge clk);
    check("first_an", 32'(an), 32'hE);
    check("first_seg", 32'(seg), 32'hC0);
    set_want(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    scan_frame();
    for (int i = 0; i < ND; i++) check($sformatf("idle_lit%0d", i), 32'(lit_cnt[i]), 32'(16 * (1 << DB)));
    check("idle_seg_bad", 32'(seg_bad), 32'h0);
    check("idle_dark", 32'(dark_bad), 32'h0);
    check("idle_multi", 32'(multi_bad), 32'h0);
    bus_read(BASE + 2, rv); check("rst_ctrl", rv, 32'h0000_00F0);
    bus_read(BASE + 0, rv); check("rst_data", rv, 32'h0);

    bus_write(BASE, 32'h0001_234F);
    bus_read(BASE, rv); check("data_rb", rv, 32'h0000_234F);
    set_want(8'h8E, 8'h99, 8'hB0, 8'hA4);
    scan_frame();
    for (int i = 0; i < ND; i++) check($sformatf("hex_seg%0d", i), 32'(seg_seen[i]), 32'(want_seg[i]));
    check("hex_seg_bad", 32'(seg_bad), 32'h0);

    bus_write(BASE + 5, 32'h0000_FFFF);
    bus_write(BASE - 1, 32'h0000_FFFF);
    bus_read(BASE + 5, rv); check("oow_read", rv, 32'h0);
    bus_read(BASE, rv); check("oow_nochange", rv, 32'h0000_234F);
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata, 32'h0000_234F);

    bus_write(BASE + 1, 32'hFFFF_FFFF);
    bus_read(BASE + 1, rv); check("dp_rb", rv, 32'h0000_000F);
    set_want(8'h0E, 8'h19, 8'h30, 8'h24);
    scan_frame();
    check("dp_seg0", 32'(seg_seen[0]), 32'h0E);
    check("dp_seg_bad", 32'(seg_bad), 32'h0);
    bus_write(BASE + 1, 32'h0);

    bus_write(BASE + 2, 32'hFFFF_FF31);
    bus_read(BASE + 2, rv); check("ctrl_mask", rv, 32'h0000_0F31);
    bus_write(BASE + 2, 32'h0000_0230);
    bus_read(BASE + 2, rv); check("ctrl_rb", rv, 32'h0000_0230);
    set_want(8'h8E, 8'h99, 8'hB0, 8'hA4);
    scan_frame();
    check("br3_lit0", 32'(lit_cnt[0]), 32'd16);
    check("br3_lit1", 32'(lit_cnt[1]), 32'd0);
    check("br3_lit2", 32'(lit_cnt[2]), 32'd16);
    check("br3_lit3", 32'(lit_cnt[3]), 32'd16);
    check("br3_dark", 32'(dark_bad), 32'h0);
    check("br3_seg_bad", 32'(seg_bad), 32'h0);

    bus_write(BASE + 2, 32'h0);
    scan_frame();
    check("br0_lit0", 32'(lit_cnt[0]), 32'd4);
    check("br0_lit3", 32'(lit_cnt[3]), 32'd4);
    check("br0_dark", 32'(dark_bad), 32'h0);

    bus_write(BASE + 2, 32'h0000_00F1);
    bus_write(BASE + 3, 32'h0000_8001);
    set_want(8'hFE, 8'h7F, 8'hFF, 8'hFF);
    scan_frame();
    check("raw_seg0", 32'(seg_seen[0]), 32'hFE);
    check("raw_seg1", 32'(seg_seen[1]), 32'h7F);
    check("raw_lit2", 32'(lit_cnt[2]), 32'd64);
    check("raw_seg_bad", 32'(seg_bad), 32'h0);
    bus_write(BASE + 4, 32'hFFFF_FFFF);
    bus_read(BASE + 4, rv); check("raw4_rb", rv, 32'h0);
    bus_read(BASE + 3, rv); check("raw3_rb", rv, 32'h0000_8001);

    k = 0;
    while (an !== 4'hB && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check("find_dig2", 32'(an), 32'hB);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_seg", 32'(seg), 32'hFF);
    check("arst_an", 32'(an), 32'hF);
    check("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    check("arst_hold_an", 32'(an), 32'hF);
    reset = 1'b0;
    @(negedge clk);
    check("post_an", 32'(an), 32'hE);
    check("post_seg", 32'(seg), 32'hC0);
    bus_read(BASE + 0, rv); check("post_data", rv, 32'h0);
    bus_read(BASE + 1, rv); check("post_dp", rv, 32'h0);
    bus_read(BASE + 2, rv); check("post_ctrl", rv, 32'h0000_00F0);
    bus_read(BASE + 3, rv); check("post_raw", rv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NDIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter BASE, default 16, word address of register 0.
REQ-003 Parameter DIVBITS, default 6, prescaler width; one scan tick per 2^DIVBITS clocks.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  bus access strobe.
REQ-007 rw  input  1  1 = write, 0 = read.
REQ-008 addr  input  32  word address.
REQ-009 data  input  32  write data.
REQ-010 rdata  output  32  registered read data.
REQ-011 seg  output  8  active-low segments; bit0..6 = a..g, bit7 = dp.
REQ-012 an  output  NDIGITS  active-low digit anodes; bit i = digit i.

Function
REQ-013 Decoded window SHALL be BASE..BASE+4; accesses outside it SHALL change no state and return rdata = 0.
REQ-014 Offset 0 DATA SHALL hold NDIGITS*4 bits; nibble i (bits 4i+3:4i) drives digit i in hex mode.
REQ-015 Offset 1 DP SHALL hold NDIGITS bits; bit i = 1 lights digit i decimal point in hex mode.
REQ-016 Offset 2 CTRL SHALL hold: bit0 RAW mode, bits 7:4 BRIGHT, bits 15:8 BLANK mask (bit 8+i blanks digit i).
REQ-017 Offsets 3 and 4 RAW SHALL hold active-high segment bytes; byte (i mod 4) of offset 3+(i/4) drives digit i in RAW mode, bit7 = dp.
REQ-018 Write (enable & rw & in window) SHALL update the addressed register at that clock edge; bits above implemented width SHALL be ignored and read back 0.
REQ-019 Read (enable & !rw) SHALL present the register value on rdata one clock later; rdata SHALL hold its value until the next read.
REQ-020 Prescaler SHALL count every clock and wrap from all-ones to 0, asserting an internal tick on the wrap cycle.
REQ-021 A 4-bit phase counter SHALL increment on each tick, wrapping 15->0.
REQ-022 Digit index SHALL advance on a tick where phase wraps 15->0, wrapping NDIGITS-1 -> 0.
REQ-023 an[idx] SHALL be 0 when phase <= BRIGHT and digit idx not blanked; all other an bits SHALL be 1.
REQ-024 When the current digit is dark (phase > BRIGHT or blanked), seg SHALL be 8'hFF.
REQ-025 Hex decode SHALL use standard glyphs (b, d lowercase): 0->C0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8, 8->80, 9->90, A->88, b->83, C->C6, d->A1, E->86, F->8E (seg[6:0], dp bit set).
REQ-026 seg[7] SHALL be ~DP[idx] in hex mode and ~RAW bit7 in RAW mode; RAW seg[6:0] SHALL be ~RAW bits 6:0.
REQ-027 seg and an SHALL be registered and change together in one clock; a register write SHALL be visible on outputs no later than the clock after the write edge.
REQ-028 Digit index change SHALL update seg and an in the same edge (no cycle showing new anode with old segments).
REQ-029 Write coinciding with tick SHALL take effect; the scan SHALL not stall or skip.
REQ-030 BRIGHT = 15 SHALL give 16/16 duty; BRIGHT = 0 SHALL give 1/16 duty per lit digit.

Reset
REQ-031 While reset is high: DATA=0, DP=0, RAW=0, CTRL.RAW=0, BLANK=0, BRIGHT=15, prescaler=0, phase=0, idx=0, rdata=0, seg=8'hFF, an=all ones.
REQ-032 Reset asserted mid-scan SHALL force the reset state immediately, independent of clk; first lit output SHALL follow on the first clock after deassertion (digit 0 showing "0", seg=C0).

Verification
REQ-033 Reset release, no writes -> each an bit low in turn for 16*2^DIVBITS clocks, seg=C0 throughout.
REQ-034 Write DATA=0x1234F, NDIGITS=4 -> digit0 seg=8E, digit1 99, digit2 B0, digit3 A4; upper bits read back 0.
REQ-035 Write CTRL=0x0000_0230 (BRIGHT=3, BLANK digit1) -> an[1] never low; other digits low exactly 4 of 16 ticks per slot.
REQ-036 Write CTRL bit0=1, RAW offset3=0x0000_8001 -> digit0 seg=FE, digit1 seg=7F.
REQ-037 Read offset 1 after writing DP=0xFFFF_FFFF -> rdata=0x0000_000F one clock after read strobe; read of BASE+5 -> 0.
REQ-038 Assert reset for one clock mid-slot of digit 2 -> outputs return immediately to seg=FF, an=all ones; registers at reset values.
